// File: rtl/registro_n_bits_universal.sv
// N-bit universal shift register: shift, rotate, load, arithmetic shift, clear,
// plus an autonomous burst mode that performs LEN single-bit shifts with BUSY/DONE.
module registro_n_bits_universal #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [2:0]       MODO,
    input  logic [N-1:0]     D,
    input  logic [CNT_W-1:0] LEN,
    input  logic             START,
    output logic [N-1:0]     Q,
    output logic             S_OUT,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               dir_lat, dir_nx;
    logic [N-1:0]       q_nx;
    logic               s_out_nx;
    logic               done_nx;

    assign BUSY = (state == BURST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            dir_lat <= 1'b0;
            Q       <= '0;
            S_OUT   <= 1'b0;
            DONE    <= 1'b0;
        end else if (ENB) begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            dir_lat <= dir_nx;
            Q       <= q_nx;
            S_OUT   <= s_out_nx;
            DONE    <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dir_nx   = dir_lat;
        q_nx     = Q;
        s_out_nx = S_OUT;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                case (MODO)
                    3'b001: begin
                        q_nx     = DIR ? {S_IN, Q[N-1:1]} : {Q[N-2:0], S_IN};
                        s_out_nx = DIR ? Q[0] : Q[N-1];
                    end
                    3'b010: begin
                        q_nx     = DIR ? {Q[0], Q[N-1:1]} : {Q[N-2:0], Q[N-1]};
                        s_out_nx = DIR ? Q[0] : Q[N-1];
                    end
                    3'b011: begin
                        q_nx     = D;
                        s_out_nx = 1'b0;
                    end
                    3'b100: begin
                        q_nx     = DIR ? {Q[N-1], Q[N-1:1]} : {Q[N-2:0], 1'b0};
                        s_out_nx = DIR ? Q[0] : Q[N-1];
                    end
                    3'b101: begin
                        // A zero-length burst completes immediately without leaving IDLE.
                        if (START) begin
                            if (LEN != '0) begin
                                dir_nx   = DIR;
                                cnt_nx   = LEN;
                                state_nx = BURST;
                            end else begin
                                done_nx = 1'b1;
                            end
                        end
                    end
                    3'b110: begin
                        q_nx     = '0;
                        s_out_nx = 1'b0;
                    end
                    default: ;
                endcase
            end
            BURST: begin
                q_nx     = dir_lat ? {S_IN, Q[N-1:1]} : {Q[N-2:0], S_IN};
                s_out_nx = dir_lat ? Q[0] : Q[N-1];
                cnt_nx   = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_registro_n_bits_universal.sv
// Bench for registro_n_bits_universal: constant vector table, hand-written burst/reset
// sequences, and randomized traffic against an arithmetic reference model.
module tb_registro_n_bits_universal;

    localparam int N = 8;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RESET, ENB, DIR, S_IN, START;
    logic [2:0]       MODO;
    logic [N-1:0]     D;
    logic [CNT_W-1:0] LEN;
    logic [N-1:0]     Q;
    logic             S_OUT, BUSY, DONE;

    int n_cmp = 0;
    int n_err = 0;

    registro_n_bits_universal #(.N(N), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .ENB(ENB), .DIR(DIR), .S_IN(S_IN), .MODO(MODO),
        .D(D), .LEN(LEN), .START(START), .Q(Q), .S_OUT(S_OUT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Reference model: remaining-shift count instead of an FSM, shifts as arithmetic.
    logic [N-1:0] m_q;
    logic         m_sout, m_busy, m_dir, m_done;
    int           m_rem;

    task automatic model_reset();
        m_q = '0; m_sout = 0; m_busy = 0; m_dir = 0; m_done = 0; m_rem = 0;
    endtask

    task automatic model_shift(input logic right, input logic fill);
        m_sout = right ? m_q[0] : m_q[N-1];
        if (right) m_q = (m_q >> 1) | (N'(fill) << (N-1));
        else       m_q = (m_q << 1) | N'(fill);
    endtask

    task automatic model_step();
        logic nd;
        logic [N-1:0] old;
        if (!ENB) return;
        nd = 0;
        old = m_q;
        if (m_busy) begin
            model_shift(m_dir, S_IN);
            m_rem--;
            if (m_rem == 0) begin m_busy = 0; nd = 1; end
        end else begin
            case (MODO)
                3'd1: model_shift(DIR, S_IN);
                3'd2: model_shift(DIR, DIR ? old[0] : old[N-1]);
                3'd3: begin m_q = D; m_sout = 0; end
                3'd4: begin
                    m_sout = DIR ? old[0] : old[N-1];
                    m_q = DIR ? N'($signed(old) >>> 1) : (old << 1);
                end
                3'd5: if (START) begin
                    if (LEN == 0) nd = 1;
                    else begin m_busy = 1; m_rem = int'(LEN); m_dir = DIR; end
                end
                3'd6: begin m_q = '0; m_sout = 0; end
                default: ;
            endcase
        end
        m_done = nd;
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_exp(input string name, input logic [N-1:0] q, input logic so,
                             input logic b, input logic dn);
        n_cmp++;
        if (Q !== q || S_OUT !== so || BUSY !== b || DONE !== dn) begin
            n_err++;
            $display("FAIL %s: got Q=%h S_OUT=%b BUSY=%b DONE=%b, want Q=%h S_OUT=%b BUSY=%b DONE=%b",
                     name, Q, S_OUT, BUSY, DONE, q, so, b, dn);
        end
    endtask

    task automatic check_model(input string name);
        check_exp(name, m_q, m_sout, m_busy, m_done);
    endtask

    typedef struct {
        logic [2:0]   modo;
        logic         dir;
        logic         s_in;
        logic [N-1:0] d;
        logic [N-1:0] q;
        logic         sout;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{3'd3, 0, 0, 8'hA5, 8'hA5, 0};
        tbl[1]  = '{3'd1, 0, 1, 8'h00, 8'h4B, 1};
        tbl[2]  = '{3'd3, 0, 0, 8'hA5, 8'hA5, 0};
        tbl[3]  = '{3'd2, 1, 0, 8'h00, 8'hD2, 1};
        tbl[4]  = '{3'd3, 0, 0, 8'h96, 8'h96, 0};
        tbl[5]  = '{3'd4, 1, 1, 8'h00, 8'hCB, 0};
        tbl[6]  = '{3'd4, 0, 1, 8'h00, 8'h96, 1};
        tbl[7]  = '{3'd6, 0, 0, 8'hFF, 8'h00, 0};
        tbl[8]  = '{3'd3, 0, 0, 8'h3C, 8'h3C, 0};
        tbl[9]  = '{3'd7, 0, 1, 8'hFF, 8'h3C, 0};
        tbl[10] = '{3'd0, 1, 1, 8'hFF, 8'h3C, 0};
        tbl[11] = '{3'd1, 1, 1, 8'h00, 8'h9E, 0};
        tbl[12] = '{3'd2, 0, 0, 8'h00, 8'h3D, 1};
        tbl[13] = '{3'd4, 1, 0, 8'h00, 8'h1E, 1};

        RESET = 1; ENB = 1; DIR = 0; S_IN = 0; START = 0; MODO = 0; D = '0; LEN = '0;
        model_reset();
        #12;
        check_exp("reset_state", 8'h00, 0, 0, 0);
        @(negedge CLK);
        RESET = 0;

        foreach (tbl[i]) begin
            MODO = tbl[i].modo; DIR = tbl[i].dir; S_IN = tbl[i].s_in; D = tbl[i].d;
            tick();
            check_exp($sformatf("table_%0d", i), tbl[i].q, tbl[i].sout, 0, 0);
        end

        // Eight right rotates are the identity.
        MODO = 3'd3; D = 8'hA5; tick();
        MODO = 3'd2; DIR = 1;
        for (int i = 0; i < 8; i++) tick();
        check_exp("rotate8_identity", 8'hA5, 1, 0, 0);

        // Burst LEN=3 right from 0x81, MODO/DIR/D scrambled while busy.
        MODO = 3'd3; D = 8'h81; tick();
        MODO = 3'd5; DIR = 1; S_IN = 0; LEN = 3; START = 1; tick();
        check_exp("burst_accept", 8'h81, 0, 1, 0);
        START = 0; MODO = 3'd3; D = 8'hFF; DIR = 0; LEN = 9;
        tick(); check_exp("burst_shift1", 8'h40, 1, 1, 0);
        MODO = 3'd6;
        tick(); check_exp("burst_shift2", 8'h20, 0, 1, 0);
        MODO = 3'd0;
        tick(); check_exp("burst_shift3_done", 8'h10, 0, 0, 1);
        tick(); check_exp("burst_done_clears", 8'h10, 0, 0, 0);

        // Burst LEN=5 left, paused for two cycles after two shifts.
        MODO = 3'd3; D = 8'h01; tick();
        MODO = 3'd5; DIR = 0; S_IN = 1; LEN = 5; START = 1; tick();
        START = 0; MODO = 3'd0;
        tick(); tick();
        check_exp("pause_before", 8'h07, 0, 1, 0);
        ENB = 0;
        tick(); check_exp("pause_1", 8'h07, 0, 1, 0);
        tick(); check_exp("pause_2", 8'h07, 0, 1, 0);
        ENB = 1;
        tick(); tick(); check_model("pause_resume");
        tick(); check_exp("pause_done", 8'h3F, 0, 0, 1);

        // Back-to-back: new START accepted while DONE is high.
        MODO = 3'd5; DIR = 1; S_IN = 1; LEN = 1; START = 1; tick();
        check_exp("b2b_accept", 8'h3F, 0, 1, 0);
        START = 0; tick();
        check_exp("b2b_done", 8'h9F, 1, 0, 1);

        // ENB=0 holds DONE high.
        MODO = 3'd5; START = 1; LEN = 0; tick();
        START = 0; ENB = 0; tick(); tick();
        check_exp("done_held_enb0", 8'h9F, 1, 0, 1);
        ENB = 1; MODO = 3'd0; tick();
        check_exp("done_clears_enb1", 8'h9F, 1, 0, 0);

        // Async reset mid-burst, then zero-length burst.
        MODO = 3'd3; D = 8'hFF; tick();
        MODO = 3'd5; DIR = 1; S_IN = 0; LEN = 6; START = 1; tick();
        START = 0; MODO = 3'd0; tick(); tick();
        check_exp("rst_pre", 8'h3F, 1, 1, 0);
        #2 RESET = 1;
        #1 check_exp("rst_async", 8'h00, 0, 0, 0);
        model_reset();
        #1 RESET = 0;
        @(posedge CLK); #1;
        check_exp("rst_stays_idle", 8'h00, 0, 0, 0);
        MODO = 3'd3; D = 8'h77; tick();
        MODO = 3'd5; LEN = 0; START = 1; tick();
        check_exp("len0_done", 8'h77, 0, 0, 1);
        START = 0; tick();
        check_exp("len0_clear", 8'h77, 0, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            MODO  = 3'($urandom_range(0, 7));
            DIR   = 1'($urandom);
            S_IN  = 1'($urandom);
            D     = N'($urandom);
            LEN   = CNT_W'($urandom_range(0, 12));
            START = ($urandom_range(0, 2) == 0);
            ENB   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) begin
                #3 RESET = 1;
                model_reset();
                #1 RESET = 0;
                check_model($sformatf("rand_rst_%0d", i));
            end
            tick();
            check_model($sformatf("rand_%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/registro_n_bits_universal.md
Name: registro_n_bits_universal

Overview:
- Parametrised N-bit universal shift register. Generalises the 4-bit register to any width.
- Adds four things: arithmetic shift, synchronous clear, an asynchronous reset, and an autonomous burst-shift mode. Burst mode performs LEN single-bit shifts under an FSM with BUSY/DONE handshake.
- Sits beside register4 and registro_4_estructural in the register test suite.
- Driven by a per-mode tester. The verificador compares its outputs against a golden model.

Parameters:
N, 8, register width in bits (N >= 2)
CNT_W, 4, width of burst length input LEN and internal counter

Ports:
CLK  input  1  clock, all state changes on rising edge
RESET  input  1  asynchronous, active-high reset
ENB  input  1  clock enable; 0 freezes all state, including FSM and counter
DIR  input  1  0 = shift/rotate left (toward MSB), 1 = right (toward LSB)
S_IN  input  1  serial input bit for logical and burst shifts
MODO  input  3  operation select (see Behaviour)
D  input  N  parallel load data
LEN  input  CNT_W  number of shifts for burst mode
START  input  1  burst start request, sampled only in IDLE with MODO=101
Q  output  N  register contents
S_OUT  output  1  registered bit shifted/rotated out on the last shift
BUSY  output  1  high while burst in progress
DONE  output  1  one-cycle pulse at burst completion

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
- While RESET=1: Q=0, S_OUT=0, BUSY=0, DONE=0, FSM=IDLE, counter=0. This applies immediately, including mid-burst.
- Enable: ENB=0 means no state change, and DONE is held at its current value.
- Latency: all modes update Q one edge after the inputs are sampled.

IDLE-state modes (ENB=1, BUSY=0):
- 000 hold: Q and S_OUT unchanged.
- 001 logical shift:
  - left: Q <= {Q[N-2:0],S_IN}, S_OUT <= Q[N-1].
  - right: Q <= {S_IN,Q[N-1:1]}, S_OUT <= Q[0].
- 010 rotate:
  - left: Q <= {Q[N-2:0],Q[N-1]}, S_OUT <= Q[N-1].
  - right: Q <= {Q[0],Q[N-1:1]}, S_OUT <= Q[0].
- 011 parallel load: Q <= D, S_OUT <= 0.
- 100 arithmetic shift (S_IN ignored):
  - right: Q <= {Q[N-1],Q[N-1:1]}, S_OUT <= Q[0].
  - left: Q <= {Q[N-2:0],0}, S_OUT <= Q[N-1].
- 101 burst:
  - START=0: hold.
  - START=1, LEN!=0: latch DIR, counter <= LEN, BUSY <= 1, go to BURST. Q unchanged at this edge.
  - START=1, LEN=0: no shift, stay IDLE, DONE <= 1 for one cycle.
- 110 synchronous clear: Q <= 0, S_OUT <= 0.
- 111 reserved: behaves as hold.

FSM, states IDLE and BURST:
- BURST with ENB=1:
  - Each edge performs one logical shift using the latched DIR and the live S_IN. S_OUT is updated as in mode 001. The counter decrements.
  - On the edge where the counter goes 1 -> 0: FSM <= IDLE, BUSY <= 0, DONE <= 1.
- BURST with ENB=0: paused; Q, counter and BUSY held.
- MODO, DIR, D, LEN and START are ignored while BUSY=1.
- Burst timing: START accepted at edge k. Shifts occur at edges k+1 .. k+LEN. BUSY is high from k to k+LEN. DONE is high for the single cycle after edge k+LEN.
- DONE clears on the next enabled edge.
- A new START is accepted in the cycle DONE is high, giving back-to-back bursts.

Width rules:
- LEN is unsigned, range 0..2^CNT_W-1.
- LEN > N is legal; the shifts continue and fill Q with S_IN history.

Test Plan:
- N=8, load D=0xA5, then MODO=001 DIR=0 S_IN=1 for one cycle -> Q=0x4B, S_OUT=1.
- Load 0xA5, MODO=010 DIR=1 -> Q=0xD2, S_OUT=1. Repeat for 7 more cycles -> Q=0xA5 (8 rotates total, identity).
- Load 0x96, MODO=100 DIR=1 -> Q=0xCB, S_OUT=0. Then DIR=0 -> Q=0x96, S_OUT=1.
- Load 0x81, MODO=101 DIR=1 S_IN=0 LEN=3 START pulse:
  - BUSY high for 3 shift cycles, with Q = 0x40, 0x20, 0x10.
  - Final S_OUT=0. DONE high exactly one cycle. MODO changes during BUSY have no effect.
- Burst LEN=5 with ENB=0 for 2 cycles mid-burst -> Q frozen and BUSY held during the pause. Completion is delayed by 2 cycles; final Q is identical to the unpaused run.
- Burst LEN=6 from 0xFF, RESET pulsed after 2 shifts, asynchronous between edges:
  - Q=0, BUSY=0, DONE=0 immediately.
  - Next START with LEN=0 -> DONE pulse next cycle, Q unchanged.
